// File: rtl/fir_pkg.sv
// Shared widths and operand/accumulator types for the FIR datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    // Default operand width (sample and coefficient) and accumulator width.
    localparam int IN_WIDTH   = 16;
    localparam int OUT_WIDTH  = 38;
    localparam int PROD_WIDTH = 2 * IN_WIDTH;

    typedef logic signed [IN_WIDTH-1:0]   sample_t;
    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [OUT_WIDTH-1:0]  acc_t;

    // Headroom above a full-precision product: this many guard bits
    // allow 2**guard_bits worst-case taps to accumulate before wrapping.
    function automatic int guard_bits(input int in_w, input int out_w);
        return out_w - 2 * in_w;
    endfunction

endpackage

// File: rtl/fir_mac_unit_if.sv
// Operand/control bundle between the FIR control FSM and the MAC core.
// Latency: n/a (wires only).
// Backpressure: none; the FSM owns pacing through en/flush.
//
// Signals:
//   flush  clear both MAC registers on the next edge (new output sample)
//   en     load enable for the product and accumulator registers
//   a, b   signed sample and coefficient operands
//   dout   registered signed accumulator value
interface fir_mac_unit_if #(
    parameter int IN_WIDTH  = fir_pkg::IN_WIDTH,
    parameter int OUT_WIDTH = fir_pkg::OUT_WIDTH
);

    logic                        flush;
    logic                        en;
    logic signed [IN_WIDTH-1:0]  a;
    logic signed [IN_WIDTH-1:0]  b;
    logic signed [OUT_WIDTH-1:0] dout;

    // Control FSM side: drives operands/control, reads the accumulator.
    modport master (
        output flush,
        output en,
        output a,
        output b,
        input  dout
    );

    // MAC core side.
    modport slave (
        input  flush,
        input  en,
        input  a,
        input  b,
        output dout
    );

endinterface

// File: rtl/fir_mac_unit_pipe_reg.sv
// Generic W-bit load-enabled register with synchronous active-high clear.
// Latency: 1 cycle from d to q when ld is high.
// Backpressure: none; holds its value whenever ld is low.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous clear, wins over ld
//   ld   load enable
//   d    next value
//   q    registered value
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // When ld is low d is never sampled, so an unknown d cannot
    // reach q while the register is holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate core: multiplier -> product register -> sign-extend/add -> accumulator.
// Latency: operands sampled at edge n are reflected in dout after edge n+1.
// Backpressure: none; en low freezes both stages, flush/rst clear both stages.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   slave side of fir_mac_unit_if (flush, en, a, b in; dout out)
module fir_mac_unit #(
    parameter int IN_WIDTH  = fir_pkg::IN_WIDTH,
    parameter int OUT_WIDTH = fir_pkg::OUT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    fir_mac_unit_if.slave   bus
);

    localparam int PW = 2 * IN_WIDTH;

    // A product must fit the accumulator without truncation.
    generate
        if (OUT_WIDTH < PW) begin : g_width_check
            $error("fir_mac_unit: OUT_WIDTH (%0d) must be >= 2*IN_WIDTH (%0d)", OUT_WIDTH, PW);
        end
    endgenerate

    logic                        clr;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_q;
    logic signed [OUT_WIDTH-1:0] prod_ext;
    logic signed [OUT_WIDTH-1:0] acc_d;
    logic signed [OUT_WIDTH-1:0] acc_q;

    // Flush behaves exactly like reset for both stages, so any partial sum
    // and the in-flight product are dropped together; flush also beats en,
    // discarding the operands presented on that cycle.
    assign clr = rst | bus.flush;

    // Full-precision signed product. Operands are widened before the
    // multiply so the result is computed at product width.
    assign prod = PW'(bus.a) * PW'(bus.b);

    pipe_reg #(
        .W (PW)
    ) u_prod_reg (
        .clk (clk),
        .rst (clr),
        .ld  (bus.en),
        .d   (prod),
        .q   (prod_q)
    );

    // Sign-extending resize of a signed value replicates the product's MSB
    // up to accumulator width. The sum wraps modulo 2**OUT_WIDTH by design.
    assign prod_ext = OUT_WIDTH'(prod_q);
    assign acc_d    = acc_q + prod_ext;

    pipe_reg #(
        .W (OUT_WIDTH)
    ) u_acc_reg (
        .clk (clk),
        .rst (clr),
        .ld  (bus.en),
        .d   (acc_d),
        .q   (acc_q)
    );

    assign bus.dout = acc_q;

endmodule

// File: tb/tb_fir_mac_unit.sv
// Self-checking bench for fir_mac_unit: directed scenarios followed by random traffic.
// Expected dout comes from a tap-list model: after each accepted tap, dout is the
// wrapped sum of every tap accepted since the last clear, excluding the newest one.
module tb_fir_mac_unit;
    import fir_pkg::*;

    logic clk;
    logic rst;

    int tests;
    int fails;

    // Products accepted since the most recent clear, oldest first.
    longint taps[$];

    fir_mac_unit_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    fir_mac_unit #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total runtime.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d required=finished", tests);
        $fatal(1, "watchdog expired");
    end

    function automatic acc_t model_dout();
        longint s;
        acc_t   r;
        s = 0;
        for (int i = 0; i < taps.size() - 1; i++) s += taps[i];
        r = s[OUT_WIDTH-1:0];
        return r;
    endfunction

    task automatic check(input string tag, input acc_t exp);
        tests++;
        assert (bus.dout === exp) else begin
            fails++;
            $error("FAIL %s: dout=%h required=%h", tag, bus.dout, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge pass, update the model, compare.
    task automatic step(input logic r, input logic f, input logic e,
                        input logic [IN_WIDTH-1:0] av, input logic [IN_WIDTH-1:0] bv,
                        input string tag);
        sample_t sa;
        sample_t sb;
        rst       = r;
        bus.flush = f;
        bus.en    = e;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        if (r || f) begin
            taps.delete();
        end else if (e) begin
            sa = av;
            sb = bv;
            taps.push_back(longint'(sa) * longint'(sb));
        end
        check(tag, model_dout());
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        bus.en    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // 1. Reset wins over en; then release and see 7*9 after two edges.
        step(1, 0, 1, 16'd7, 16'd9, "rst_hold0");
        step(1, 0, 1, 16'd7, 16'd9, "rst_hold1");
        step(0, 0, 1, 16'd7, 16'd9, "rst_rel_edge1");
        check("rst_rel_edge1_const", 38'd0);
        step(0, 0, 1, 16'd7, 16'd9, "rst_rel_edge2");
        check("rst_rel_edge2_const", 38'd63);

        // 2. Latency and accumulation.
        step(0, 1, 0, 16'd0, 16'd0, "lat_flush");
        step(0, 0, 1, 16'd3, 16'd4, "lat_e1");
        step(0, 0, 1, 16'd0, 16'd0, "lat_e2");
        check("lat_12", 38'd12);
        step(0, 0, 1, 16'd0, 16'd0, "lat_e3");
        step(0, 0, 1, 16'd5, 16'd6, "lat_e4");
        step(0, 0, 1, 16'd0, 16'd0, "lat_e5");
        check("lat_42", 38'd42);

        // 3. Signed products and sign extension.
        step(0, 1, 0, 16'd0, 16'd0, "sgn_flush");
        step(0, 0, 1, 16'hFFFE, 16'd5, "sgn_e1");
        step(0, 0, 1, 16'hFFFD, 16'hFFFD, "sgn_e2");
        check("sgn_m10", 38'h3F_FFFF_FFF6);
        step(0, 0, 1, 16'd0, 16'd0, "sgn_e3");
        check("sgn_m1", 38'h3F_FFFF_FFFF);

        // 4. Wrap: 256 products of 2**30 sum to 2**38 == 0 modulo accumulator width.
        step(0, 1, 0, 16'd0, 16'd0, "wrap_flush");
        for (int i = 0; i < 256; i++) step(0, 0, 1, 16'h8000, 16'h8000, "wrap_run");
        check("wrap_255", 38'h3F_C000_0000);
        step(0, 0, 1, 16'd0, 16'd0, "wrap_last");
        check("wrap_zero", 38'd0);

        // 5. Flush together with en discards that cycle's operands.
        step(0, 1, 0, 16'd0, 16'd0, "fl_flush0");
        step(0, 0, 1, 16'd3, 16'd4, "fl_e1");
        step(0, 0, 1, 16'd0, 16'd0, "fl_e2");
        step(0, 1, 1, 16'd9, 16'd9, "fl_flush_en");
        check("fl_cleared", 38'd0);
        step(0, 0, 1, 16'd0, 16'd0, "fl_after1");
        step(0, 0, 1, 16'd0, 16'd0, "fl_after2");
        check("fl_stays0", 38'd0);

        // 6. Enable low holds both stages, even with unknown operands.
        step(0, 1, 0, 16'd0, 16'd0, "hold_flush");
        step(0, 0, 1, 16'd2, 16'd3, "hold_e1");
        step(0, 0, 1, 16'd7, 16'd7, "hold_e2");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'd100, 16'd100, "hold_en0");
        check("hold_dout6", 38'd6);
        step(0, 0, 0, 16'hxxxx, 16'hxxxx, "hold_x");
        step(0, 0, 1, 16'd0, 16'd0, "hold_release");
        check("hold_prod49", 38'd55);
        step(0, 0, 1, 16'd0, 16'd0, "hold_release2");
        check("hold_no_x", 38'd55);

        // Random traffic including occasional flush/reset and extreme operands.
        for (int i = 0; i < 400; i++) begin
            logic [IN_WIDTH-1:0] ra;
            logic [IN_WIDTH-1:0] rb;
            int sel;
            sel = $urandom_range(0, 3);
            ra  = (sel == 0) ? 16'h8000 : IN_WIDTH'($urandom);
            rb  = (sel == 1) ? 16'h7FFF : IN_WIDTH'($urandom);
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 75), ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
